beam_uart_streamer: RTL and testbench

Downstream stage of the 8-channel delay-and-sum beamformer. Accepts the 40-bit beamformed sum produced during the summing phase, buffers it in an on-chip FIFO, and serialises each sample as five bytes, MSB byte first, on an 8N1 UART transmit line. The summer emits a sample every 2 clocks, while the UART drains one sample per 50 bit-times. The FIFO absorbs a full 540-sample beam line without loss.

---
 rtl/beam_uart_streamer.sv | 156 +++++++++++++++
 tb/tb_beam_uart_streamer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/beam_uart_streamer.sv
// Beamformer output streamer: a 40-bit sample FIFO drained by an 8N1 UART,
// five bytes per sample, MSB byte first, each byte LSB first.
module beam_uart_streamer #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_AW      = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [39:0]      sample_in,
  input  logic             sample_valid,
  output logic             tx,
  output logic             busy,
  output logic             overflow,
  output logic [FIFO_AW:0] fifo_level
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);

  localparam logic [FIFO_AW:0]   FULL    = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [CW-1:0]      CNT_MAX = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]      CNT_ONE = CW'(1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;

  logic [39:0]        mem [DEPTH];
  logic [39:0]        rd_word_q;

  logic [2:0]         state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2:0]         bit_q, bit_d;
  logic [2:0]         byte_q, byte_d;
  logic [39:0]        shreg_q, shreg_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   level_q, level_d;
  logic               ovf_q, ovf_d;

  logic               wr_en;
  logic               rd_en;
  logic               tick;
  logic [7:0]         cur_byte;

  // Full check uses the registered level, so a same-cycle read never frees a slot.
  assign wr_en    = sample_valid && (level_q != FULL);
  assign rd_en    = (state_q == S_IDLE) && (level_q != '0);
  assign tick     = (cnt_q == CNT_MAX);
  assign cur_byte = shreg_q[39:32];

  always_comb begin
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    level_d  = level_q;
    if (wr_en && !rd_en)
      level_d = level_q + LVL_ONE;
    else if (rd_en && !wr_en)
      level_d = level_q - LVL_ONE;
    ovf_d = ovf_q | (sample_valid & ~wr_en);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = tick ? '0 : cnt_q + CNT_ONE;
    bit_d   = bit_q;
    byte_d  = byte_q;
    shreg_d = shreg_q;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (rd_en) state_d = S_FETCH;
      end
      S_FETCH: begin
        cnt_d   = '0;
        shreg_d = rd_word_q;
        byte_d  = '0;
        state_d = S_START;
      end
      S_START: begin
        if (tick) begin
          bit_d   = '0;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (tick) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (tick) begin
          if (byte_q < 3'd4) begin
            byte_d  = byte_q + 3'd1;
            shreg_d = {shreg_q[31:0], 8'h00};
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_comb begin
    tx = 1'b1;
    if (state_q == S_START)
      tx = 1'b0;
    else if (state_q == S_DATA)
      tx = cur_byte[bit_q];
  end

  assign busy       = (level_q != '0) || (state_q != S_IDLE);
  assign overflow   = ovf_q;
  assign fifo_level = level_q;

  // Storage is not reset; emptiness is tracked by the pointers and level.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr_q] <= sample_in;
    if (rd_en) rd_word_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shreg_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shreg_q  <= shreg_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

endmodule

// File: tb/tb_beam_uart_streamer.sv
// Directed bench for beam_uart_streamer: a deep-FIFO instance for framing,
// burst and reset cases, and a 4-deep instance for the overflow cases.
module tb_beam_uart_streamer;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [39:0] in_b = '0;
  logic [39:0] in_s = '0;
  logic        v_b = 1'b0;
  logic        v_s = 1'b0;
  logic        tx_b, busy_b, ovf_b;
  logic [10:0] lvl_b;
  logic        tx_s, busy_s, ovf_s;
  logic [2:0]  lvl_s;
  logic        sel = 1'b0;
  logic        tx_mon;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  int          c;
  int          t0;
  int          tb_t, tb_tp;
  int          ts;
  logic [39:0] w;
  logic [39:0] wb;
  logic [39:0] ws;
  int          lv_exp [6] = '{1, 1, 2, 3, 4, 4};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign tx_mon = sel ? tx_s : tx_b;

  beam_uart_streamer #(.CLKS_PER_BIT(CPB), .FIFO_AW(10)) u_big (
    .clk(clk), .rst(rst), .sample_in(in_b), .sample_valid(v_b),
    .tx(tx_b), .busy(busy_b), .overflow(ovf_b), .fifo_level(lvl_b)
  );

  beam_uart_streamer #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) u_small (
    .clk(clk), .rst(rst), .sample_in(in_s), .sample_valid(v_s),
    .tx(tx_s), .busy(busy_s), .overflow(ovf_s), .fifo_level(lvl_s)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic strobe(input logic s, input logic [39:0] v);
    if (s) begin in_s = v; v_s = 1'b1; end
    else begin in_b = v; v_b = 1'b1; end
    @(negedge clk);
    if (s) v_s = 1'b0;
    else v_b = 1'b0;
  endtask

  task automatic wait_low(input int bound, output int cnt);
    cnt = 0;
    while (tx_mon !== 1'b0 && cnt < bound) begin
      @(negedge clk);
      cnt++;
    end
  endtask

  task automatic recv_byte(output logic [7:0] b);
    repeat (2) @(negedge clk);
    chk("start_bit", 64'(tx_mon), 64'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      b[i] = tx_mon;
    end
    repeat (CPB) @(negedge clk);
    chk("stop_bit", 64'(tx_mon), 64'd1);
  endtask

  task automatic recv_sample(output logic [39:0] word, output int start);
    int          g;
    logic [7:0]  b;
    word  = '0;
    start = 0;
    for (int k = 0; k < 5; k++) begin
      wait_low(1000, g);
      if (k == 0) start = cyc;
      else chk("byte_gap", 64'(g), 64'd2);
      recv_byte(b);
      word = {word[31:0], b};
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_tx_b", 64'(tx_b), 64'd1);
    chk("rst_busy_b", 64'(busy_b), 64'd0);
    chk("rst_ovf_b", 64'(ovf_b), 64'd0);
    chk("rst_lvl_b", 64'(lvl_b), 64'd0);
    chk("rst_tx_s", 64'(tx_s), 64'd1);
    chk("rst_lvl_s", 64'(lvl_s), 64'd0);

    // single sample
    strobe(1'b0, 40'h123456789A);
    chk("single_lvl", 64'(lvl_b), 64'd1);
    wait_low(20, c);
    chk("first_low_delay", 64'(c + 1), 64'd3);
    recv_sample(w, t0);
    chk("single_word", 64'(w), 64'h123456789A);
    @(negedge clk);
    chk("last_stop_tx", 64'(tx_b), 64'd1);
    chk("last_stop_busy", 64'(busy_b), 64'd1);
    @(negedge clk);
    chk("busy_fall", 64'(busy_b), 64'd0);
    chk("frame_len", 64'(cyc - t0), 64'd200);

    // negative values go out as raw two's complement
    strobe(1'b0, 40'hFFFFFFFFFF);
    recv_sample(w, t0);
    chk("neg1_word", 64'(w), 64'hFFFFFFFFFF);
    strobe(1'b0, 40'hFFFFFFFFFE);
    recv_sample(w, t0);
    chk("neg2_word", 64'(w), 64'hFFFFFFFFFE);
    repeat (4) @(negedge clk);
    chk("neg_idle_busy", 64'(busy_b), 64'd0);

    // burst: with CPB=4 reads land on cycles 1+202j, so 6 reads by the last write
    fork
      begin
        for (int i = 0; i < 540; i++) begin
          strobe(1'b0, 40'(i));
          @(negedge clk);
        end
      end
      begin
        tb_tp = 0;
        for (int j = 0; j < 3; j++) begin
          recv_sample(wb, tb_t);
          chk("burst_word", 64'(wb), 64'(j));
          if (j > 0) chk("burst_spacing", 64'(tb_t - tb_tp), 64'd202);
          tb_tp = tb_t;
        end
      end
    join
    chk("burst_lvl", 64'(lvl_b), 64'd534);
    chk("burst_ovf", 64'(ovf_b), 64'd0);

    // reset while busy with a full backlog
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst2_tx", 64'(tx_b), 64'd1);
    chk("rst2_lvl", 64'(lvl_b), 64'd0);
    chk("rst2_busy", 64'(busy_b), 64'd0);

    // reset during DATA of byte 2 with 3 words queued
    for (int i = 0; i < 4; i++) strobe(1'b0, 40'hA0 + 40'(i));
    chk("queued_lvl", 64'(lvl_b), 64'd3);
    repeat (96) @(negedge clk);
    chk("mid_busy", 64'(busy_b), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_tx", 64'(tx_b), 64'd1);
    chk("mid_rst_lvl", 64'(lvl_b), 64'd0);
    chk("mid_rst_busy", 64'(busy_b), 64'd0);
    strobe(1'b0, 40'h00FF00FF80);
    wait_low(20, c);
    chk("post_rst_delay", 64'(c + 1), 64'd3);
    recv_sample(w, t0);
    chk("post_rst_word", 64'(w), 64'h00FF00FF80);
    repeat (2) @(negedge clk);
    chk("post_rst_idle", 64'(busy_b), 64'd0);

    // overflow on a 4-deep FIFO
    sel = 1'b1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          strobe(1'b1, 40'(i));
          chk("ovf_level", 64'(lvl_s), 64'(lv_exp[i]));
          chk("ovf_flag", 64'(ovf_s), 64'(i == 5));
        end
      end
      begin
        for (int j = 0; j < 5; j++) begin
          recv_sample(ws, ts);
          chk("ovf_word", 64'(ws), 64'(j));
        end
      end
    join
    repeat (2) @(negedge clk);
    chk("ovf_drain_busy", 64'(busy_s), 64'd0);
    chk("ovf_sticky", 64'(ovf_s), 64'd1);
    wait_low(300, c);
    chk("no_sample5", 64'(c), 64'd300);

    // full FIFO, strobe lands on the IDLE read cycle
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst3_ovf", 64'(ovf_s), 64'd0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 40'd16 + 40'(i));
    chk("full_lvl", 64'(lvl_s), 64'd4);
    repeat (198) @(negedge clk);
    chk("pre_read_lvl", 64'(lvl_s), 64'd4);
    chk("pre_read_ovf", 64'(ovf_s), 64'd0);
    chk("pre_read_tx", 64'(tx_s), 64'd1);
    strobe(1'b1, 40'h99);
    chk("full_rd_lvl", 64'(lvl_s), 64'd3);
    chk("full_rd_ovf", 64'(ovf_s), 64'd1);
    recv_sample(ws, ts);
    chk("full_rd_word", 64'(ws), 64'd17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
